guess_game_ctrl: RTL

Parametrised controller for the multi-level switch-guessing game. It latches a random target per level and shows the level-masked target on LEDs while a round is live. It judges the player's guess against a per-level countdown with a retry budget, and drives the level, beep and display requests. Sits between the debounced button/switch inputs and the existing LFSR, beeper, 7-segment and dot-matrix drivers.

---
 rtl/guess_game_pkg.sv | 29 ++
 rtl/guess_game_ctrl_if.sv | 29 ++
 rtl/guess_game_ctrl_level_timer.sv | 31 +++
 rtl/guess_game_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared types and helpers for the switch-guessing game controller.
// State codes double as the display/matrix select value.
package guess_game_pkg;

    localparam int LEVEL_W = 3;
    localparam int TRIES_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GREET   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_PLAY    = 3'd3,
        ST_JUDGE   = 3'd4,
        ST_VICTORY = 3'd5,
        ST_FAIL    = 3'd6
    } state_e;

    // Number of compared bits at a given level.
    function automatic int mask_width(input int base_w, input logic [LEVEL_W-1:0] lvl);
        return base_w + int'(lvl);
    endfunction

    function automatic logic [15:0] level_mask(input int base_w, input logic [LEVEL_W-1:0] lvl);
        logic [31:0] ones;
        ones = (32'd1 << mask_width(base_w, lvl)) - 32'd1;
        return ones[15:0];
    endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Player/LFSR/display-side signal bundle of the guessing game controller.
// master drives the game inputs; slave is the controller.
interface guess_game_if #(
    parameter int MAX_W = 7
);
    logic             en;
    logic             start_p;
    logic             restart_p;
    logic [MAX_W-1:0] guess;
    logic [MAX_W-1:0] rand_val;
    logic             rand_req;
    logic [MAX_W-1:0] led;
    logic [2:0]       level;
    logic [3:0]       tries_left;
    logic [2:0]       state_o;
    logic             beep_p;
    logic             win;
    logic             lose;

    modport master (
        output en, start_p, restart_p, guess, rand_val,
        input  rand_req, led, level, tries_left, state_o, beep_p, win, lose
    );

    modport slave (
        input  en, start_p, restart_p, guess, rand_val,
        output rand_req, led, level, tries_left, state_o, beep_p, win, lose
    );
endinterface

// File: rtl/guess_game_ctrl_level_timer.sv
// Loadable, saturating down-counter giving the per-attempt guess deadline.
// zero is high while the count rests at 0.
module level_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Countdown register: load has priority, decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/guess_game_ctrl.sv
// Multi-level switch-guessing game controller: target latching, guess judging
// with deadline and retry budget, and level/beep/display requests.
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int LEVELS      = 3,
    parameter int BASE_W      = 5,
    parameter int MAX_W       = BASE_W + LEVELS - 1,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int MAX_TRIES   = 3
) (
    input logic         clk,
    input logic         rst,
    guess_game_if.slave bus
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0]   TMR_RELOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TRIES_W-1:0] TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS - 1);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_GREET   = ST_GREET;
    localparam logic [2:0] S_LOAD    = ST_LOAD;
    localparam logic [2:0] S_PLAY    = ST_PLAY;
    localparam logic [2:0] S_JUDGE   = ST_JUDGE;
    localparam logic [2:0] S_VICTORY = ST_VICTORY;
    localparam logic [2:0] S_FAIL    = ST_FAIL;

    function automatic logic [MAX_W-1:0] lvl_mask(input logic [LEVEL_W-1:0] lvl);
        logic [15:0] full;
        full = level_mask(BASE_W, lvl);
        return full[MAX_W-1:0];
    endfunction

    logic [2:0]         state_r,   state_s;
    logic [LEVEL_W-1:0] level_r,   level_s;
    logic [TRIES_W-1:0] tries_r,   tries_s;
    logic [MAX_W-1:0]   target_r,  target_s;
    logic [MAX_W-1:0]   guess_r,   guess_s;
    logic               timeout_r, timeout_s;
    logic [MAX_W-1:0]   led_r,     led_s;
    logic               req_r,     req_s;
    logic               beep_r,    beep_s;
    logic               win_r;
    logic               lose_r;
    logic               match_s;
    logic               tmr_load_s;
    logic               tmr_dec_s;
    logic               tmr_zero_s;

    level_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .en       (tmr_dec_s),
        .load_val (TMR_RELOAD),
        .zero     (tmr_zero_s)
    );

    // A timed-out attempt can never match, whatever the switches show.
    assign match_s = ~timeout_r &&
                     (((guess_r ^ target_r) & lvl_mask(level_r)) == {MAX_W{1'b0}});

    // Next-state and datapath decisions.
    always_comb begin
        state_s    = state_r;
        level_s    = level_r;
        tries_s    = tries_r;
        target_s   = target_r;
        guess_s    = guess_r;
        timeout_s  = timeout_r;
        req_s      = 1'b0;
        beep_s     = 1'b0;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;

        if (!bus.en) begin
            state_s = S_IDLE;
            level_s = {LEVEL_W{1'b0}};
            tries_s = TRIES_INIT;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_GREET;
                end
                S_GREET: begin
                    if (bus.restart_p) begin
                        state_s = S_LOAD;
                        level_s = {LEVEL_W{1'b0}};
                        req_s   = 1'b1;
                    end else begin
                        state_s = S_GREET;
                    end
                end
                S_LOAD: begin
                    // First LOAD cycle carries the request; the LFSR answers in the second.
                    if (req_r) begin
                        state_s = S_LOAD;
                    end else begin
                        target_s   = bus.rand_val;
                        tries_s    = TRIES_INIT;
                        tmr_load_s = 1'b1;
                        state_s    = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (bus.restart_p) begin
                        state_s = S_LOAD;
                        level_s = {LEVEL_W{1'b0}};
                        req_s   = 1'b1;
                    end else if (bus.start_p) begin
                        guess_s   = bus.guess;
                        timeout_s = 1'b0;
                        state_s   = S_JUDGE;
                    end else if (tmr_zero_s) begin
                        timeout_s = 1'b1;
                        state_s   = S_JUDGE;
                    end else begin
                        tmr_dec_s = 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (match_s) begin
                        if (level_r < LAST_LEVEL) begin
                            level_s = level_r + LEVEL_W'(1);
                            req_s   = 1'b1;
                            state_s = S_LOAD;
                        end else begin
                            beep_s  = 1'b1;
                            state_s = S_VICTORY;
                        end
                    end else begin
                        beep_s = 1'b1;
                        if (tries_r > TRIES_W'(1)) begin
                            tries_s    = tries_r - TRIES_W'(1);
                            tmr_load_s = 1'b1;
                            state_s    = S_PLAY;
                        end else begin
                            tries_s = {TRIES_W{1'b0}};
                            state_s = S_FAIL;
                        end
                    end
                end
                S_VICTORY, S_FAIL: begin
                    if (bus.restart_p) begin
                        state_s = S_LOAD;
                        level_s = {LEVEL_W{1'b0}};
                        req_s   = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    level_s = {LEVEL_W{1'b0}};
                    tries_s = TRIES_INIT;
                end
            endcase
        end
    end

    // LEDs follow the state being entered so they are never a cycle stale.
    always_comb begin
        if (state_s == S_PLAY) begin
            led_s = target_s & lvl_mask(level_s);
        end else begin
            led_s = {MAX_W{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            level_r   <= {LEVEL_W{1'b0}};
            tries_r   <= TRIES_INIT;
            target_r  <= {MAX_W{1'b0}};
            guess_r   <= {MAX_W{1'b0}};
            timeout_r <= 1'b0;
            led_r     <= {MAX_W{1'b0}};
            req_r     <= 1'b0;
            beep_r    <= 1'b0;
            win_r     <= 1'b0;
            lose_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            level_r   <= level_s;
            tries_r   <= tries_s;
            target_r  <= target_s;
            guess_r   <= guess_s;
            timeout_r <= timeout_s;
            led_r     <= led_s;
            req_r     <= req_s;
            beep_r    <= beep_s;
            win_r     <= (state_s == S_VICTORY);
            lose_r    <= (state_s == S_FAIL);
        end
    end

    assign bus.rand_req   = req_r;
    assign bus.led        = led_r;
    assign bus.level      = level_r;
    assign bus.tries_left = tries_r;
    assign bus.state_o    = state_r;
    assign bus.beep_p     = beep_r;
    assign bus.win        = win_r;
    assign bus.lose       = lose_r;

endmodule
